// File: rtl/dmux_stream_1xn_pkg.sv
// Shared defaults and helpers for the 1-to-N stream demux.
// Optional feature macro: DMUX_CNT_EN (per-channel delivered-beat counters).
package dmux_pkg;
  localparam int DMUX_WIDTH_DEF = 4;
  localparam int DMUX_NCH_DEF   = 4;
  localparam int DMUX_CNT_W     = 8;

  // Select width: at least one bit even for a two-channel build.
  function automatic int dmux_sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/dmux_stream_1xn_if.sv
// Upstream beat plus per-channel downstream handshakes of the demux.
// Optional feature macro: DMUX_CNT_EN (counters are a separate top port).
interface dmux_stream_1xn_if import dmux_pkg::*; #(
  parameter int WIDTH = DMUX_WIDTH_DEF,
  parameter int NCH   = DMUX_NCH_DEF
);
  localparam int SEL_W = dmux_sel_w(NCH);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic                   in_bcast;
  logic [NCH-1:0]         out_valid;
  logic [NCH-1:0]         out_ready;
  logic [NCH*WIDTH-1:0]   out_data;
  logic                   drop;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, drop
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, drop
  );
endinterface

// File: rtl/dmux_stream_1xn_slot.sv
// One output channel: single-entry buffer, optional delivered-beat counter.
// Optional feature macro: DMUX_CNT_EN.
module dmux_slot import dmux_pkg::*; #(
  parameter int WIDTH = DMUX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             ready_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
`ifdef DMUX_CNT_EN
  ,
  output logic [DMUX_CNT_W-1:0] cnt_o
`endif
);
  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             hs;

  assign hs = full_q & ready_i;

  // A load wins over a drain so drain-and-refill keeps the slot full.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (hs) begin
      full_d = 1'b0;
    end
  end

  // Buffer state; payload is only ever replaced by a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

`ifdef DMUX_CNT_EN
  logic [DMUX_CNT_W-1:0] cnt_q, cnt_d;

  // Count output handshakes, wrapping naturally at the counter width.
  always_comb begin
    cnt_d = cnt_q;
    if (hs) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`endif
endmodule

// File: rtl/dmux_stream_1xn.sv
// 1-to-N stream demultiplexer with unicast, broadcast and out-of-range drop.
// Optional feature macro: DMUX_CNT_EN adds the cnt port (8-bit per channel).
module dmux_stream_1xn import dmux_pkg::*; #(
  parameter int WIDTH = DMUX_WIDTH_DEF,
  parameter int NCH   = DMUX_NCH_DEF
) (
  input  logic clk,
  input  logic rst,
  dmux_stream_1xn_if.slave bus
`ifdef DMUX_CNT_EN
  ,
  output logic [NCH*DMUX_CNT_W-1:0] cnt
`endif
);
  localparam int SEL_W = dmux_sel_w(NCH);

  logic [NCH-1:0]            can_take;
  logic [NCH-1:0]            load;
  logic [NCH-1:0]            full_w;
  logic [NCH-1:0][WIDTH-1:0] data_w;
  logic                      sel_ok;
  logic                      ready;
  logic                      accept;
  logic                      drop_q, drop_d;

  assign can_take = ~full_w | bus.out_ready;
  assign sel_ok   = {1'b0, bus.in_sel} < (SEL_W+1)'(NCH);

  // Readiness depends only on sel/bcast/buffer state, never on in_valid.
  always_comb begin
    ready = 1'b0;
    if (bus.in_bcast) begin
      ready = &can_take;
    end else if (!sel_ok) begin
      ready = 1'b1;
    end else begin
      for (int i = 0; i < NCH; i++)
        if (bus.in_sel == SEL_W'(i)) ready = can_take[i];
    end
  end

  assign accept = bus.in_valid & ready;

  // Steer the accepted beat; broadcast loads every channel at once.
  always_comb begin
    load = '0;
    for (int i = 0; i < NCH; i++)
      load[i] = accept & (bus.in_bcast | (bus.in_sel == SEL_W'(i)));
  end

  assign drop_d = accept & ~bus.in_bcast & ~sel_ok;

  // Registered drop pulse for beats discarded by an out-of-range select.
  always_ff @(posedge clk) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= drop_d;
  end

`ifdef DMUX_CNT_EN
  logic [NCH-1:0][DMUX_CNT_W-1:0] cnt_w;
  assign cnt = cnt_w;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_slot
    dmux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load[i]),
      .ready_i (bus.out_ready[i]),
      .data_i  (bus.in_data),
      .full_o  (full_w[i]),
      .data_o  (data_w[i])
`ifdef DMUX_CNT_EN
      ,
      .cnt_o   (cnt_w[i])
`endif
    );
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = full_w;
  assign bus.out_data  = data_w;
  assign bus.drop      = drop_q;
endmodule

// File: tb/tb_dmux_stream_1xn.sv
// Self-checking bench for dmux_stream_1xn: a 4-channel and a 3-channel instance.
// Optional feature macro: DMUX_CNT_EN (counter checks compiled in when defined).
module tb_dmux_stream_1xn;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmux_stream_1xn_if #(.WIDTH(4), .NCH(4)) b4();
  dmux_stream_1xn_if #(.WIDTH(4), .NCH(3)) b3();

`ifdef DMUX_CNT_EN
  logic [31:0] cnt4;
  logic [23:0] cnt3;
`endif

  dmux_stream_1xn #(.WIDTH(4), .NCH(4)) u4 (
    .clk(clk), .rst(rst), .bus(b4)
`ifdef DMUX_CNT_EN
    , .cnt(cnt4)
`endif
  );

  dmux_stream_1xn #(.WIDTH(4), .NCH(3)) u3 (
    .clk(clk), .rst(rst), .bus(b3)
`ifdef DMUX_CNT_EN
    , .cnt(cnt3)
`endif
  );

  typedef struct { int ch; logic [3:0] d; } beat_t;
  beat_t      sb[$];
  beat_t      bt;
  logic [3:0] md[4];   // expected held payload per channel of the 4-ch DUT
  int         passed = 0;
  int         total  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle4();
    b4.in_valid = 1'b0; b4.in_bcast = 1'b0; b4.in_sel = '0; b4.in_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle4();
    b4.out_ready = 4'b0000;
    b3.in_valid = 1'b0; b3.in_bcast = 1'b0; b3.in_sel = '0; b3.in_data = '0;
    b3.out_ready = 3'b000;
    tick(); tick();
    total++; if (b4.out_valid !== 4'b0000) $display("FAIL reset_valid got %b want 0000", b4.out_valid); else passed++;
    total++; if (b4.out_data !== 16'h0) $display("FAIL reset_data got %h want 0000", b4.out_data); else passed++;
    total++; if (b4.drop !== 1'b0) $display("FAIL reset_drop got %b want 0", b4.drop); else passed++;
    total++; if (b4.in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", b4.in_ready); else passed++;
    total++; if (b3.out_valid !== 3'b000) $display("FAIL reset_valid3 got %b want 000", b3.out_valid); else passed++;
`ifdef DMUX_CNT_EN
    total++; if (cnt4 !== 32'h0) $display("FAIL reset_cnt got %h want 0", cnt4); else passed++;
`endif
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) md[i] = 4'h0;
  endtask

  task automatic test_sweep();
    b4.out_ready = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      for (int d = 0; d < 16; d++) begin
        b4.in_valid = 1'b1; b4.in_sel = 2'(s); b4.in_data = 4'(d);
        #1;
        total++; if (b4.in_ready !== 1'b1) $display("FAIL sweep_ready sel=%0d got %b want 1", s, b4.in_ready); else passed++;
        sb.push_back('{s, 4'(d)});
        tick();
        bt = sb.pop_front();
        md[bt.ch] = bt.d;
        total++; if (b4.out_valid !== 4'(1 << bt.ch)) $display("FAIL sweep_valid sel=%0d got %b want %b", bt.ch, b4.out_valid, 4'(1 << bt.ch)); else passed++;
        for (int c = 0; c < 4; c++) begin
          total++; if (b4.out_data[c*4 +: 4] !== md[c]) $display("FAIL sweep_data ch=%0d got %h want %h", c, b4.out_data[c*4 +: 4], md[c]); else passed++;
        end
      end
    end
    idle4();
    tick();
    total++; if (b4.out_valid !== 4'b0000) $display("FAIL sweep_drain got %b want 0000", b4.out_valid); else passed++;
  endtask

  task automatic test_backpressure();
    b4.out_ready = 4'b1011;
    b4.in_valid = 1'b1; b4.in_sel = 2'd2; b4.in_data = 4'hA;
    sb.push_back('{2, 4'hA});
    tick();
    bt = sb.pop_front();
    total++; if (b4.out_valid[2] !== 1'b1 || b4.out_data[8 +: 4] !== bt.d) $display("FAIL bp_first got v=%b d=%h want v=1 d=%h", b4.out_valid[2], b4.out_data[8 +: 4], bt.d); else passed++;
    b4.in_data = 4'hB;
    #1;
    total++; if (b4.in_ready !== 1'b0) $display("FAIL bp_stall_ready got %b want 0", b4.in_ready); else passed++;
    tick();
    total++; if (b4.out_valid[2] !== 1'b1 || b4.out_data[8 +: 4] !== 4'hA) $display("FAIL bp_hold got v=%b d=%h want v=1 d=a", b4.out_valid[2], b4.out_data[8 +: 4]); else passed++;
    b4.out_ready = 4'b1111;
    #1;
    total++; if (b4.in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", b4.in_ready); else passed++;
    sb.push_back('{2, 4'hB});
    tick();
    bt = sb.pop_front();
    md[2] = bt.d;
    total++; if (b4.out_valid !== 4'b0100 || b4.out_data[8 +: 4] !== bt.d) $display("FAIL bp_refill got v=%b d=%h want v=0100 d=%h", b4.out_valid, b4.out_data[8 +: 4], bt.d); else passed++;
    idle4();
    tick();
    total++; if (b4.out_valid !== 4'b0000) $display("FAIL bp_drain got %b want 0000", b4.out_valid); else passed++;
  endtask

  task automatic test_bcast();
    b4.out_ready = 4'b1101;
    b4.in_valid = 1'b1; b4.in_sel = 2'd1; b4.in_data = 4'h3;
    tick();
    md[1] = 4'h3;
    b4.in_bcast = 1'b1; b4.in_sel = 2'd3; b4.in_data = 4'h5;
    #1;
    total++; if (b4.in_ready !== 1'b0) $display("FAIL bc_block_ready got %b want 0", b4.in_ready); else passed++;
    tick();
    total++; if (b4.out_valid !== 4'b0010) $display("FAIL bc_block_valid got %b want 0010", b4.out_valid); else passed++;
    for (int c = 0; c < 4; c++) begin
      total++; if (b4.out_data[c*4 +: 4] !== md[c]) $display("FAIL bc_block_data ch=%0d got %h want %h", c, b4.out_data[c*4 +: 4], md[c]); else passed++;
    end
    b4.out_ready = 4'b1111;
    #1;
    total++; if (b4.in_ready !== 1'b1) $display("FAIL bc_go_ready got %b want 1", b4.in_ready); else passed++;
    for (int c = 0; c < 4; c++) sb.push_back('{c, 4'h5});
    tick();
    idle4();
    total++; if (b4.out_valid !== 4'b1111) $display("FAIL bc_valid got %b want 1111", b4.out_valid); else passed++;
    while (sb.size() > 0) begin
      bt = sb.pop_front();
      md[bt.ch] = bt.d;
      total++; if (b4.out_data[bt.ch*4 +: 4] !== bt.d) $display("FAIL bc_data ch=%0d got %h want %h", bt.ch, b4.out_data[bt.ch*4 +: 4], bt.d); else passed++;
    end
    tick();
    total++; if (b4.out_valid !== 4'b0000) $display("FAIL bc_drain got %b want 0000", b4.out_valid); else passed++;
  endtask

  task automatic test_out_of_range();
    b3.out_ready = 3'b110;
    b3.in_valid = 1'b1; b3.in_sel = 2'd0; b3.in_data = 4'h2;
    tick();
    b3.in_sel = 2'd3; b3.in_data = 4'h7;
    #1;
    total++; if (b3.in_ready !== 1'b1) $display("FAIL oor_ready got %b want 1", b3.in_ready); else passed++;
    total++; if (b3.drop !== 1'b0) $display("FAIL oor_drop_early got %b want 0", b3.drop); else passed++;
    tick();
    b3.in_valid = 1'b0;
    total++; if (b3.drop !== 1'b1) $display("FAIL oor_drop got %b want 1", b3.drop); else passed++;
    total++; if (b3.out_valid !== 3'b001 || b3.out_data !== 12'h002) $display("FAIL oor_out got v=%b d=%h want v=001 d=002", b3.out_valid, b3.out_data); else passed++;
    tick();
    total++; if (b3.drop !== 1'b0) $display("FAIL oor_drop_clear got %b want 0", b3.drop); else passed++;
    total++; if (b3.out_valid !== 3'b001) $display("FAIL oor_hold got %b want 001", b3.out_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    b4.out_ready = 4'b0000;
    b4.in_valid = 1'b1; b4.in_sel = 2'd0; b4.in_data = 4'h9;
    tick();
    b4.in_sel = 2'd3; b4.in_data = 4'hC;
    tick();
    idle4();
    total++; if (b4.out_valid !== 4'b1001) $display("FAIL rm_pre got %b want 1001", b4.out_valid); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (b4.out_valid !== 4'b0000) $display("FAIL rm_valid got %b want 0000", b4.out_valid); else passed++;
    total++; if (b4.out_data !== 16'h0) $display("FAIL rm_data got %h want 0000", b4.out_data); else passed++;
    total++; if (b3.out_valid !== 3'b000) $display("FAIL rm_valid3 got %b want 000", b3.out_valid); else passed++;
`ifdef DMUX_CNT_EN
    total++; if (cnt4 !== 32'h0) $display("FAIL rm_cnt got %h want 0", cnt4); else passed++;
`endif
    tick();
    total++; if (b4.out_valid !== 4'b0000) $display("FAIL rm_after got %b want 0000", b4.out_valid); else passed++;
  endtask

`ifdef DMUX_CNT_EN
  task automatic test_cnt();
    b4.out_ready = 4'b1111;
    b4.in_valid = 1'b1; b4.in_sel = 2'd0; b4.in_data = 4'h1;
    for (int k = 0; k < 257; k++) tick();
    idle4();
    tick();
    total++; if (cnt4[7:0] !== 8'd1) $display("FAIL cnt_wrap got %0d want 1", cnt4[7:0]); else passed++;
    total++; if (cnt4[31:8] !== 24'h0) $display("FAIL cnt_others got %h want 0", cnt4[31:8]); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_sweep();
    test_backpressure();
    test_bcast();
    test_out_of_range();
    test_reset_mid();
`ifdef DMUX_CNT_EN
    test_cnt();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
